// File: rtl/fpu_seq.sv
// Issue/completion sequencer in front of the multicycle fpu: one op in flight, operands held for the op latency.
// Optional macro FPU_SEQ_ERR_EN adds the rsp_err output flagging illegal opcodes.
module fpu_seq #(
    parameter int          TAG_W    = 5,
    parameter logic [3:0]  IDLE_OP  = 4'b1111,
    parameter int          LAT_DIV  = 3,
    parameter int          LAT_SQRT = 2,
    parameter int          LAT_ONE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [3:0]       fpu_op,
    input  logic [31:0]      fpu_result,
    input  logic [31:0]      fpu_int_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_is_int,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
`ifdef FPU_SEQ_ERR_EN
    ,
    output logic             rsp_err
`endif
);

    localparam int LAT_MAX = (LAT_DIV > LAT_SQRT) ? ((LAT_DIV > LAT_ONE) ? LAT_DIV : LAT_ONE)
                                                  : ((LAT_SQRT > LAT_ONE) ? LAT_SQRT : LAT_ONE);
    localparam int CNT_W   = (LAT_MAX > 0) ? $clog2(LAT_MAX + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [TAG_W-1:0]   tag_q;
    logic               accept;
    logic               done;

    // Cycles the fpu needs after its inputs settle before the selected output is valid.
    function automatic logic [CNT_W-1:0] op_lat(input logic [3:0] op);
        case (op)
            4'b0011:                                    op_lat = CNT_W'(LAT_DIV);
            4'b0100:                                    op_lat = CNT_W'(LAT_SQRT);
            4'b0000, 4'b0001, 4'b0010,
            4'b0101, 4'b0110, 4'b0111:                  op_lat = CNT_W'(LAT_ONE);
            default:                                    op_lat = '0;
        endcase
    endfunction

    function automatic logic op_is_int(input logic [3:0] op);
        op_is_int = (op == 4'b0110) || (op == 4'b1000) || (op == 4'b1001);
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        op_illegal = (op >= 4'b1010);
    endfunction

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // fpu_op stays at the issued op through EXEC so every past_op stage of the fpu matches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_op     <= IDLE_OP;
            fpu_a      <= '0;
            fpu_b      <= '0;
            tag_q      <= '0;
            cnt        <= '0;
            rsp_data   <= '0;
            rsp_tag    <= '0;
            rsp_is_int <= 1'b0;
        end else if (accept) begin
            fpu_op <= req_op;
            fpu_a  <= req_a;
            fpu_b  <= req_b;
            tag_q  <= req_tag;
            cnt    <= op_lat(req_op);
        end else if (state == EXEC) begin
            if (!done) begin
                cnt <= cnt - CNT_W'(1);
            end else begin
                if (op_illegal(fpu_op))     rsp_data <= '0;
                else if (op_is_int(fpu_op)) rsp_data <= fpu_int_result;
                else                        rsp_data <= fpu_result;
                rsp_is_int <= op_is_int(fpu_op);
                rsp_tag    <= tag_q;
                fpu_op     <= IDLE_OP;
            end
        end
    end

`ifdef FPU_SEQ_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)                          rsp_err <= 1'b0;
        else if (done)                    rsp_err <= op_illegal(fpu_op);
        else if (rsp_valid && rsp_ready)  rsp_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_fpu_seq.sv
// Scoreboard bench for fpu_seq with a latency-aware fpu stand-in driven from a table of known vectors.
module tb_fpu_seq;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic [3:0]       fpu_op;
    logic [31:0]      fpu_result;
    logic [31:0]      fpu_int_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_is_int;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
`ifdef FPU_SEQ_ERR_EN
    logic             rsp_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fpu_seq #(.TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_tag        (req_tag),
        .fpu_a          (fpu_a),
        .fpu_b          (fpu_b),
        .fpu_op         (fpu_op),
        .fpu_result     (fpu_result),
        .fpu_int_result (fpu_int_result),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_is_int     (rsp_is_int),
        .rsp_tag        (rsp_tag),
        .busy           (busy)
`ifdef FPU_SEQ_ERR_EN
        ,
        .rsp_err        (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    // fpu stand-in: outputs are only valid once its inputs have been stable for the op latency.
    typedef struct packed {
        logic [31:0] res;
        logic [31:0] ires;
        int          need;
    } fpu_out_t;

    function automatic fpu_out_t fpu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        fpu_out_t o;
        o.res  = 32'h7FC0_0001;
        o.ires = 32'h0000_BAD0;
        o.need = 0;
        case (op)
            4'b0000: begin o.need = 1; if (a == 32'h3F80_0000 && b == 32'h4000_0000) o.res = 32'h4040_0000; end
            4'b0001: begin o.need = 1; if (a == 32'h4040_0000 && b == 32'h3F80_0000) o.res = 32'h4000_0000; end
            4'b0010: begin o.need = 1; if (a == 32'h4000_0000 && b == 32'h4040_0000) o.res = 32'h40C0_0000; end
            4'b0011: begin o.need = 3; if (a == 32'h40C0_0000 && b == 32'h4000_0000) o.res = 32'h4040_0000; end
            4'b0100: begin o.need = 2; if (a == 32'h4080_0000) o.res = 32'h4000_0000; end
            4'b0101: begin o.need = 1; if (a == 32'h4049_0FDB) o.res = 32'h4040_0000; end
            4'b0110: begin o.need = 1; if (a == 32'h4049_0FDB) o.ires = 32'd3; end
            4'b0111: begin o.need = 1; if (a == 32'd5) o.res = 32'h40A0_0000; end
            4'b1000: begin o.ires = (a == b) ? 32'd1 : 32'd0; end
            4'b1001: begin
                if (a == 32'h3F80_0000 && b == 32'h4000_0000) o.ires = 32'd1;
                if (a == 32'h4000_0000 && b == 32'h3F80_0000) o.ires = 32'd0;
            end
            4'b1111: begin o.res = 32'h0; o.ires = 32'h0; end
            default: begin o.res = 32'hA5A5_A5A5; o.ires = 32'h5A5A_5A5A; end
        endcase
        return o;
    endfunction

    logic [31:0] pa = '0, pb = '0;
    logic [3:0]  po = '0;
    int          age = 0;
    int          stable;
    fpu_out_t    fo;

    always @(posedge clk) begin
        age <= (fpu_a == pa && fpu_b == pb && fpu_op == po) ? age + 1 : 0;
        pa  <= fpu_a;
        pb  <= fpu_b;
        po  <= fpu_op;
    end

    always_comb begin
        stable = (fpu_a == pa && fpu_b == pb && fpu_op == po) ? age + 1 : 0;
        fo     = fpu_fn(fpu_op, fpu_a, fpu_b);
        if (stable >= fo.need) begin
            fpu_result     = fo.res;
            fpu_int_result = fo.ires;
        end else begin
            fpu_result     = 32'hDEAD_BEEF;
            fpu_int_result = 32'hDEAD_BEEF;
        end
    end

    typedef struct {
        logic [31:0]      data;
        logic             is_int;
        logic             err;
        logic [TAG_W-1:0] tag;
        int               lat;
        logic [3:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        check("req_ready_at_issue", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 4'($urandom);
        req_tag   = TAG_W'($urandom);
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   k;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        k = -1;
        for (int i = 0; i <= 20; i++) begin
            if (rsp_valid) begin
                k = i;
                break;
            end
            check("exec_hold_op", {28'b0, fpu_op}, {28'b0, e.op});
            check("exec_hold_a", fpu_a, e.a);
            check("exec_hold_b", fpu_b, e.b);
            @(posedge clk); #1;
        end
        if (k < 0) begin
            check("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", 32'(k), 32'(e.lat + 1));
        check("rsp_data", rsp_data, e.data);
        check("rsp_tag", {27'b0, rsp_tag}, {27'b0, e.tag});
        check("rsp_is_int", {31'b0, rsp_is_int}, {31'b0, e.is_int});
        check("fpu_op_idle", {28'b0, fpu_op}, 32'hF);
`ifdef FPU_SEQ_ERR_EN
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
`endif
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                req_op    = 4'b0010;
                req_a     = 32'h4000_0000;
                req_b     = 32'h4040_0000;
                req_tag   = 5'd30;
                req_valid = 1'b1;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("bp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_data", rsp_data, e.data);
            check("bp_tag", {27'b0, rsp_tag}, {27'b0, e.tag});
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("post_req_ready", {31'b0, req_ready}, 32'd1);
        check("post_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic op_test(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, input logic [31:0] data,
                           input logic is_int, input int lat, input int hold);
        sb.push_back('{data: data, is_int: is_int, err: (op >= 4'b1010), tag: tag,
                       lat: lat, op: op, a: a, b: b});
        issue(op, a, b, tag);
        collect(hold);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (n_fail %0d)", n_fail);
        $fatal(1);
    end

    initial begin
        int seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'b0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_fpu_op", {28'b0, fpu_op}, 32'hF);
        check("rst_fpu_a", fpu_a, 32'd0);
        check("rst_fpu_b", fpu_b, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_tag", {27'b0, rsp_tag}, 32'd0);
        check("rst_rsp_is_int", {31'b0, rsp_is_int}, 32'd0);
`ifdef FPU_SEQ_ERR_EN
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
`endif

        op_test(4'b0000, 32'h3F80_0000, 32'h4000_0000, 5'd3,  32'h4040_0000, 1'b0, 1, 0);
        op_test(4'b0011, 32'h40C0_0000, 32'h4000_0000, 5'd7,  32'h4040_0000, 1'b0, 3, 0);
        op_test(4'b0100, 32'h4080_0000, 32'h0000_0000, 5'd9,  32'h4000_0000, 1'b0, 2, 0);
        op_test(4'b1001, 32'h3F80_0000, 32'h4000_0000, 5'd10, 32'd1,         1'b1, 0, 0);
        op_test(4'b0110, 32'h4049_0FDB, 32'h0000_0000, 5'd12, 32'd3,         1'b1, 1, 5);

        // The pulse raised under backpressure must not have started an op.
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy) seen++;
        end
        check("bp_pulse_ignored", 32'(seen), 32'd0);

        // Reset lands on the edge where the fdiv counter reads 1.
        issue(4'b0011, 32'h40C0_0000, 32'h4000_0000, 5'd8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_fdiv_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_fpu_op", {28'b0, fpu_op}, 32'hF);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        seen = 0;
        repeat (6) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_rsp", 32'(seen), 32'd0);

        op_test(4'b0010, 32'h4000_0000, 32'h4040_0000, 5'd21, 32'h40C0_0000, 1'b0, 1, 0);
        op_test(4'b0001, 32'h4040_0000, 32'h3F80_0000, 5'd1,  32'h4000_0000, 1'b0, 1, 0);
        op_test(4'b1000, 32'h3F80_0000, 32'h3F80_0000, 5'd31, 32'd1,         1'b1, 0, 0);
        op_test(4'b1001, 32'h4000_0000, 32'h3F80_0000, 5'd11, 32'd0,         1'b1, 0, 0);
        op_test(4'b0111, 32'd5,         32'h0000_0000, 5'd2,  32'h40A0_0000, 1'b0, 1, 0);
        op_test(4'b0101, 32'h4049_0FDB, 32'h0000_0000, 5'd4,  32'h4040_0000, 1'b0, 1, 2);
        op_test(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, 32'd0,         1'b0, 0, 0);
        op_test(4'b0000, 32'h3F80_0000, 32'h4000_0000, 5'd0,  32'h4040_0000, 1'b0, 1, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
